regdecr_stream: RTL and testbench

Stream-side counterpart to the register-incrementer: accepts an nbits start value over a val/rdy input port, then emits the descending sequence start, start-1, …, 0 on a val/rdy output port, one message per accepted transfer. The decrement datapath is a ripple chain of FA_X1 full adders, so the block goes through the same gate-level flow as the incrementer. It sits between a value producer and any consumer that needs a bounded countdown stream.

---
 rtl/regdecr_pkg.sv | 11 +
 rtl/regdecr_stream_if.sv | 33 +++
 rtl/regdecr_cells.sv | 23 ++
 rtl/regdecr_decr.sv | 39 +++
 rtl/regdecr_stream.sv | 71 +++++++
 tb/tb_regdecr_stream.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/regdecr_pkg.sv
// Shared types and defaults for the stream countdown block.
package regdecr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int NBITS_DEFAULT = 8;

endpackage

// File: rtl/regdecr_stream_if.sv
// Input start-value port and output countdown port of regdecr_stream.
interface regdecr_stream_if
    import regdecr_pkg::*;
#(
    parameter int nbits = NBITS_DEFAULT
);

    logic             in_val;
    logic             in_rdy;
    logic [nbits-1:0] in_msg;
    logic             out_val;
    logic             out_rdy;
    logic [nbits-1:0] out_msg;

    modport master (
        output in_val,
        output in_msg,
        output out_rdy,
        input  in_rdy,
        input  out_val,
        input  out_msg
    );

    modport slave (
        input  in_val,
        input  in_msg,
        input  out_rdy,
        output in_rdy,
        output out_val,
        output out_msg
    );

endinterface

// File: rtl/regdecr_cells.sv
// Behavioural views of the library cells used by the decrementer.
module FA_X1 (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);
    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (A & CI) | (B & CI);
endmodule

module LOGIC1_X1 (
    output logic Z
);
    assign Z = 1'b1;
endmodule

module LOGIC0_X1 (
    output logic Z
);
    assign Z = 1'b0;
endmodule

// File: rtl/regdecr_decr.sv
// Ripple-carry decrementer: a + all-ones through one full adder per bit.
module regdecr_decr #(
    parameter int nbits = 8
) (
    input  logic [nbits-1:0] a,
    output logic [nbits-1:0] y
);

    logic             one;
    logic             zero;
    logic [nbits-1:0] c;

    LOGIC1_X1 u_tie1 (.Z(one));
    LOGIC0_X1 u_tie0 (.Z(zero));

    assign c[0] = zero;

    // Final carry-out is dropped; the countdown never wraps.
    for (genvar i = 0; i < nbits; i++) begin : g_bit
        if (i == nbits - 1) begin : g_last
            FA_X1 u_fa (
                .A (a[i]),
                .B (one),
                .CI(c[i]),
                .S (y[i]),
                .CO()
            );
        end else begin : g_mid
            FA_X1 u_fa (
                .A (a[i]),
                .B (one),
                .CI(c[i]),
                .S (y[i]),
                .CO(c[i+1])
            );
        end
    end

endmodule

// File: rtl/regdecr_stream.sv
// Accepts a start value and streams start, start-1, ..., 0 downstream.
module regdecr_stream
    import regdecr_pkg::*;
#(
    parameter int nbits = NBITS_DEFAULT
) (
    input  logic             CK,
    input  logic             RN,
    regdecr_stream_if.slave  bus,
    output logic             busy
);

    state_t           state;
    state_t           state_nx;
    logic [nbits-1:0] count;
    logic [nbits-1:0] count_nx;
    logic [nbits-1:0] dec;

    regdecr_decr #(.nbits(nbits)) u_decr (
        .a(count),
        .y(dec)
    );

    always_ff @(posedge CK) begin
        if (!RN) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        bus.in_rdy  = 1'b0;
        bus.out_val = 1'b0;
        bus.out_msg = count;
        busy        = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_rdy = 1'b1;
                if (bus.in_val) begin
                    count_nx = bus.in_msg;
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                bus.out_val = 1'b1;
                busy        = 1'b1;
                if (bus.out_rdy) begin
                    if (count == '0) begin
                        state_nx = IDLE;
                    end else begin
                        count_nx = dec;
                    end
                end
            end
            default: ;
        endcase
        // Reset masks every output regardless of the registered state.
        if (!RN) begin
            bus.in_rdy  = 1'b0;
            bus.out_val = 1'b0;
            bus.out_msg = '0;
            busy        = 1'b0;
        end
    end

endmodule

// File: tb/tb_regdecr_stream.sv
// Randomized and directed checks of regdecr_stream against a queue model.
module tb_regdecr_stream;

    logic CK = 1'b0;
    logic RN = 1'b0;
    logic busy8;
    logic busy4;
    int   passed = 0;
    int   total  = 0;

    regdecr_stream_if #(.nbits(8)) b8 ();
    regdecr_stream_if #(.nbits(4)) b4 ();

    regdecr_stream #(.nbits(8)) dut8 (
        .CK  (CK),
        .RN  (RN),
        .bus (b8),
        .busy(busy8)
    );

    regdecr_stream #(.nbits(4)) dut4 (
        .CK  (CK),
        .RN  (RN),
        .bus (b4),
        .busy(busy4)
    );

    always #5 CK = ~CK;

    // Streams n..0 out of the 8-bit block; mode 0: ready high,
    // 1: fixed stall pattern, 2: random ready.
    task automatic run8(input logic [7:0] n, input int mode);
        logic [7:0] q[$];
        int         pat[9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
        int         cyc = 0;
        int         sent = 0;
        logic [7:0] prev = '0;
        bit         stall = 0;
        for (int v = int'(n); v >= 0; v--) q.push_back(8'(v));
        total++;
        if (b8.in_rdy !== 1'b1) begin
            $display("FAIL accept_rdy n=%0d in_rdy=%b want 1", n, b8.in_rdy);
        end else passed++;
        b8.in_val  = 1'b1;
        b8.in_msg  = n;
        b8.out_rdy = 1'b1;
        @(posedge CK); #1;
        b8.in_val = 1'b0;
        b8.in_msg = 8'($urandom);
        while (q.size() > 0 && cyc < 2000) begin
            total++;
            if (b8.out_val !== 1'b1 || b8.out_msg !== q[0]) begin
                $display("FAIL stream_msg n=%0d val=%b msg=%0d want 1/%0d",
                         n, b8.out_val, b8.out_msg, q[0]);
            end else passed++;
            total++;
            if (busy8 !== 1'b1 || b8.in_rdy !== 1'b0) begin
                $display("FAIL count_flags busy=%b in_rdy=%b want 1/0",
                         busy8, b8.in_rdy);
            end else passed++;
            if (stall) begin
                total++;
                if (b8.out_msg !== prev) begin
                    $display("FAIL stall_stable msg=%0d want %0d",
                             b8.out_msg, prev);
                end else passed++;
            end
            case (mode)
                1:       b8.out_rdy = (cyc < 9) ? 1'(pat[cyc]) : 1'b1;
                2:       b8.out_rdy = 1'($urandom_range(0, 1));
                default: b8.out_rdy = 1'b1;
            endcase
            prev  = b8.out_msg;
            stall = !b8.out_rdy;
            @(posedge CK); #1;
            if (b8.out_rdy) begin
                void'(q.pop_front());
                sent++;
            end
            cyc++;
        end
        total++;
        if (q.size() != 0 || sent != int'(n) + 1) begin
            $display("FAIL stream_len n=%0d sent=%0d want %0d", n, sent, n + 1);
        end else passed++;
        total++;
        if (b8.in_rdy !== 1'b1 || b8.out_val !== 1'b0 || busy8 !== 1'b0) begin
            $display("FAIL back_idle rdy=%b val=%b busy=%b want 1/0/0",
                     b8.in_rdy, b8.out_val, busy8);
        end else passed++;
        b8.out_rdy = 1'b1;
    endtask

    task automatic test_reset();
        RN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CK); #1;
            total++;
            if (b8.in_rdy !== 1'b0 || b8.out_val !== 1'b0 ||
                busy8 !== 1'b0 || b8.out_msg !== 8'd0) begin
                $display("FAIL reset_out rdy=%b val=%b busy=%b msg=%0d want 0",
                         b8.in_rdy, b8.out_val, busy8, b8.out_msg);
            end else passed++;
        end
        RN = 1'b1;
        #1;
        total++;
        if (b8.in_rdy !== 1'b1 || b8.out_val !== 1'b0 || busy8 !== 1'b0 ||
            b4.in_rdy !== 1'b1) begin
            $display("FAIL reset_idle rdy=%b val=%b busy=%b want 1/0/0",
                     b8.in_rdy, b8.out_val, busy8);
        end else passed++;
    endtask

    task automatic test_countdown();
        run8(8'd3, 0);
    endtask

    task automatic test_zero();
        run8(8'd0, 0);
    endtask

    task automatic test_backpressure();
        run8(8'd5, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            run8(8'($urandom_range(0, 40)), 2);
        end
        run8(8'd255, 0);
    endtask

    task automatic test_full_range();
        int expv = 15;
        int cyc = 0;
        b4.out_rdy = 1'b1;
        b4.in_val  = 1'b1;
        b4.in_msg  = 4'd15;
        @(posedge CK); #1;
        b4.in_msg = 4'd7;
        while (expv >= 0 && cyc < 100) begin
            total++;
            if (b4.out_val !== 1'b1 || b4.out_msg !== 4'(expv) ||
                b4.in_rdy !== 1'b0) begin
                $display("FAIL full_msg val=%b msg=%0d rdy=%b want 1/%0d/0",
                         b4.out_val, b4.out_msg, b4.in_rdy, expv);
            end else passed++;
            @(posedge CK); #1;
            expv--;
            cyc++;
        end
        total++;
        if (cyc != 16 || b4.in_rdy !== 1'b1 || b4.out_val !== 1'b0) begin
            $display("FAIL full_end cyc=%0d rdy=%b val=%b want 16/1/0",
                     cyc, b4.in_rdy, b4.out_val);
        end else passed++;
        @(posedge CK); #1;
        b4.in_val = 1'b0;
        total++;
        if (b4.out_val !== 1'b1 || b4.out_msg !== 4'd7 || busy4 !== 1'b1) begin
            $display("FAIL held_accept val=%b msg=%0d busy=%b want 1/7/1",
                     b4.out_val, b4.out_msg, busy4);
        end else passed++;
        cyc = 0;
        while (b4.in_rdy !== 1'b1 && cyc < 50) begin
            @(posedge CK); #1;
            cyc++;
        end
        total++;
        if (cyc != 8) begin
            $display("FAIL held_drain cycles=%0d want 8", cyc);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        b8.out_rdy = 1'b1;
        b8.in_val  = 1'b1;
        b8.in_msg  = 8'd200;
        @(posedge CK); #1;
        b8.in_val = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (b8.out_val !== 1'b1 || b8.out_msg !== 8'(200 - i)) begin
                $display("FAIL mid_msg val=%b msg=%0d want 1/%0d",
                         b8.out_val, b8.out_msg, 200 - i);
            end else passed++;
            @(posedge CK); #1;
        end
        RN = 1'b0;
        #1;
        total++;
        if (b8.out_val !== 1'b0 || b8.in_rdy !== 1'b0 || busy8 !== 1'b0) begin
            $display("FAIL mid_rst val=%b rdy=%b busy=%b want 0/0/0",
                     b8.out_val, b8.in_rdy, busy8);
        end else passed++;
        @(posedge CK); #1;
        RN = 1'b1;
        #1;
        total++;
        if (b8.out_val !== 1'b0 || b8.in_rdy !== 1'b1 ||
            b8.out_msg !== 8'd0) begin
            $display("FAIL mid_idle val=%b rdy=%b msg=%0d want 0/1/0",
                     b8.out_val, b8.in_rdy, b8.out_msg);
        end else passed++;
        run8(8'd2, 0);
    endtask

    initial begin
        b8.in_val  = 1'b0;
        b8.in_msg  = '0;
        b8.out_rdy = 1'b1;
        b4.in_val  = 1'b0;
        b4.in_msg  = '0;
        b4.out_rdy = 1'b1;
        test_reset();
        test_countdown();
        test_zero();
        test_backpressure();
        test_random();
        test_full_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
